// File: rtl/dm_stage.sv
// Data-memory stage: word-addressed RAM with byte-lane store merging,
// sign/zero-extended combinational loads, address-error flags and a store trace.
module dm_stage #(
    parameter int unsigned DEPTH = 3072,
    parameter logic [31:0] BASE  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  load_op,
    input  logic [1:0]  store_op,
    input  logic [31:0] pc,
    output logic [31:0] rdata,
    output logic        adel,
    output logic        ades,
    output logic        we_trace,
    output logic [31:0] waddr_trace,
    output logic [31:0] wdata_trace,
    output logic [31:0] pc_trace
);
    localparam int unsigned IW    = $clog2(DEPTH);
    localparam logic [31:0] LIMIT = 32'(4 * DEPTH);

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_W    = 3'd1,
        LD_H    = 3'd2,
        LD_HU   = 3'd3,
        LD_B    = 3'd4,
        LD_BU   = 3'd5
    } load_e;

    typedef enum logic [1:0] {
        ST_NONE = 2'd0,
        ST_W    = 2'd1,
        ST_H    = 2'd2,
        ST_B    = 2'd3
    } store_e;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   offset;
    logic          in_range;
    logic [IW-1:0] idx;
    logic [31:0]   word;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic          ld_mis;
    logic          st_mis;
    logic          ld_valid;
    logic          commit;
    logic [31:0]   merged;

    assign offset   = addr - BASE;
    // Unsigned compare also catches addresses that wrapped below BASE.
    assign in_range = offset < LIMIT;
    assign idx      = offset[IW+1:2];
    assign word     = in_range ? mem[idx] : '0;

    always_comb begin
        lane_b = '0;
        unique case (addr[1:0])
            2'd0: lane_b = word[7:0];
            2'd1: lane_b = word[15:8];
            2'd2: lane_b = word[23:16];
            2'd3: lane_b = word[31:24];
        endcase
    end

    assign lane_h = addr[1] ? word[31:16] : word[15:0];

    always_comb begin
        ld_valid = 1'b1;
        ld_mis   = 1'b0;
        case (load_e'(load_op))
            LD_W:         ld_mis = addr[1:0] != 2'b00;
            LD_H, LD_HU:  ld_mis = addr[0];
            LD_B, LD_BU:  ld_mis = 1'b0;
            default:      ld_valid = 1'b0;
        endcase
    end

    always_comb begin
        st_mis = 1'b0;
        case (store_e'(store_op))
            ST_W:    st_mis = addr[1:0] != 2'b00;
            ST_H:    st_mis = addr[0];
            default: st_mis = 1'b0;
        endcase
    end

    assign adel = ld_valid && (ld_mis || !in_range);
    assign ades = (store_op != 2'd0) && (st_mis || !in_range);

    always_comb begin
        rdata = '0;
        if (!adel) begin
            case (load_e'(load_op))
                LD_W:    rdata = word;
                LD_H:    rdata = {{16{lane_h[15]}}, lane_h};
                LD_HU:   rdata = {16'h0000, lane_h};
                LD_B:    rdata = {{24{lane_b[7]}}, lane_b};
                LD_BU:   rdata = {24'h00_0000, lane_b};
                default: rdata = '0;
            endcase
        end
    end

    always_comb begin
        merged = word;
        case (store_e'(store_op))
            ST_W: merged = wdata;
            ST_H: begin
                if (addr[1]) merged[31:16] = wdata[15:0];
                else         merged[15:0]  = wdata[15:0];
            end
            ST_B: begin
                unique case (addr[1:0])
                    2'd0: merged[7:0]   = wdata[7:0];
                    2'd1: merged[15:8]  = wdata[7:0];
                    2'd2: merged[23:16] = wdata[7:0];
                    2'd3: merged[31:24] = wdata[7:0];
                endcase
            end
            default: merged = word;
        endcase
    end

    assign commit = (store_op != 2'd0) && !ades;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            we_trace    <= 1'b0;
            waddr_trace <= '0;
            wdata_trace <= '0;
            pc_trace    <= '0;
        end else begin
            we_trace <= commit;
            if (commit) begin
                mem[idx]    <= merged;
                waddr_trace <= {addr[31:2], 2'b00};
                wdata_trace <= merged;
                pc_trace    <= pc;
            end
        end
    end
endmodule
